// File: rtl/wishbone_master.sv
// Wishbone classic single-cycle initiator: one bus cycle per accepted command, one-cycle response pulse.
// Optional bus timeout abort is built only when WB_MASTER_TIMEOUT_EN is defined.
module wishbone_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_adr_i,
  input  logic [DATA_W-1:0] cmd_dat_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_dat_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic [DATA_W-1:0] dat_o,
  input  logic [DATA_W-1:0] dat_i,
  output logic              we_o,
  output logic              sel_o,
  output logic              stb_o,
  output logic              cyc_o,
  input  logic              ack_i
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUS  = 1'b1;

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic [0:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  // State and output registers; async reset drops the bus strobes immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = rsp_dat_q;
`ifdef WB_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          state_d = ST_BUS;
          cyc_d   = 1'b1;
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_we_i ? cmd_dat_i : '0;
`ifdef WB_MASTER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_BUS: begin
        if (ack_i) begin
          state_d     = ST_IDLE;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? '0 : dat_i;
`ifdef WB_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_IDLE;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d       = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  assign cmd_ready_o = ready_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = cyc_q;
  assign sel_o       = cyc_q;
  assign busy_o      = cyc_q;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
`ifdef WB_MASTER_TIMEOUT_EN
  assign rsp_err_o   = rsp_err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wishbone_master.sv
// Directed bench for wishbone_master: per-cycle vector table plus reset/timeout/race sequences.
module tb_wishbone_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [DW-1:0] cmd_dat = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_dat;
  logic          rsp_err;
  logic          busy;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i = '0;
  logic          we, sel, stb, cyc;
  logic          ack = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wishbone_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err), .busy_o(busy),
    .adr_o(adr), .dat_o(dat_o), .dat_i(dat_i), .we_o(we), .sel_o(sel),
    .stb_o(stb), .cyc_o(cyc), .ack_i(ack)
  );

  typedef struct {
    logic        cv;
    logic        cwe;
    logic [31:0] cadr;
    logic [31:0] cdat;
    logic        ack;
    logic [31:0] di;
    logic        e_cyc;
    logic        e_rdy;
    logic        e_rv;
    logic [31:0] e_rdat;
    logic [31:0] e_adr;
    logic [31:0] e_dat;
    logic        e_we;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    int low_cnt;
    int rv_cnt;
    bit got;

    //        cv   we    cadr          cdat          ack   dat_i         cyc  rdy  rv   rsp_dat       adr_o         dat_o         we_o
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h11111111, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b1, 32'h00000000, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'hA5A5A5A5, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'hA5A5A5A5, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'hA5A5A5A5, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h77777777, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h00000010, 32'hFFFF0000, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h00000010, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h00000020, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h00000010, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h00000020, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h00000020, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h12345678, 1'b0, 1'b1, 1'b1, 32'h12345678, 32'h00000020, 32'h0,        1'b0};
    vecs[10] = '{1'b1, 1'b1, 32'h00000030, 32'h00000055, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 32'h12345678, 32'h00000030, 32'h00000055, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'h00000040, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 32'h0,        32'h00000030, 32'h00000055, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        32'h00000030, 32'h00000055, 1'b0};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_cyc",   32'(cyc), 32'd0);
    chk("rst_stb",   32'(stb), 32'd0);
    chk("rst_sel",   32'(sel), 32'd0);
    chk("rst_we",    32'(we), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_rv",    32'(rsp_valid), 32'd0);
    chk("rst_err",   32'(rsp_err), 32'd0);
    chk("rst_adr",   adr, 32'h0);
    chk("rst_dat",   dat_o, 32'h0);
    chk("rst_rdat",  rsp_dat, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Per-cycle vector table
    for (int i = 0; i < 13; i++) begin
      cmd_valid = vecs[i].cv; cmd_we = vecs[i].cwe; cmd_adr = vecs[i].cadr; cmd_dat = vecs[i].cdat;
      ack = vecs[i].ack; dat_i = vecs[i].di;
      step();
      chk($sformatf("v%0d_cyc", i),   32'(cyc), 32'(vecs[i].e_cyc));
      chk($sformatf("v%0d_stb", i),   32'(stb), 32'(vecs[i].e_cyc));
      chk($sformatf("v%0d_sel", i),   32'(sel), 32'(vecs[i].e_cyc));
      chk($sformatf("v%0d_busy", i),  32'(busy), 32'(vecs[i].e_cyc));
      chk($sformatf("v%0d_ready", i), 32'(cmd_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_rv", i),    32'(rsp_valid), 32'(vecs[i].e_rv));
      chk($sformatf("v%0d_rdat", i),  rsp_dat, vecs[i].e_rdat);
      chk($sformatf("v%0d_err", i),   32'(rsp_err), 32'd0);
      chk($sformatf("v%0d_adr", i),   adr, vecs[i].e_adr);
      chk($sformatf("v%0d_dat", i),   dat_o, vecs[i].e_dat);
      chk($sformatf("v%0d_we", i),    32'(we), 32'(vecs[i].e_we));
    end
    cmd_valid = 1'b0; ack = 1'b0; dat_i = '0;

    // Asynchronous reset in the middle of a bus cycle
    issue(1'b0, 32'h00000044, 32'h0);
    chk("mid_cyc_before", 32'(cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_cyc_async",   32'(cyc), 32'd0);
    chk("mid_stb_async",   32'(stb), 32'd0);
    chk("mid_ready_async", 32'(cmd_ready), 32'd1);
    step();
    chk("mid_rv_inrst", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    ack = 1'b1;
    step();
    chk("mid_rv_after1", 32'(rsp_valid), 32'd0);
    chk("mid_cyc_after", 32'(cyc), 32'd0);
    ack = 1'b0;
    step();
    chk("mid_rv_after2", 32'(rsp_valid), 32'd0);

`ifdef WB_MASTER_TIMEOUT_EN
    // Timeout on an unmapped address
    issue(1'b0, 32'hBAD00000, 32'h0);
    cnt = 0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (cyc) cnt++;
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("to_rsp_seen", 32'(got), 32'd1);
    chk("to_cyc_len",  32'(cnt), 32'(TO));
    chk("to_err",      32'(rsp_err), 32'd1);
    chk("to_rdat",     rsp_dat, 32'h0);
    chk("to_ready",    32'(cmd_ready), 32'd1);
    chk("to_we",       32'(we), 32'd0);
    step();
    chk("to_rv_drop",  32'(rsp_valid), 32'd0);
    chk("to_err_hold", 32'(rsp_err), 32'd1);

    // Ack on the last BUS cycle wins over the timeout
    issue(1'b0, 32'h00000080, 32'h0);
    for (int k = 0; k < 15; k++) step();
    chk("race_cyc_pre", 32'(cyc), 32'd1);
    chk("race_rv_pre",  32'(rsp_valid), 32'd0);
    ack = 1'b1; dat_i = 32'hCAFEF00D;
    step();
    ack = 1'b0; dat_i = '0;
    chk("race_rv",   32'(rsp_valid), 32'd1);
    chk("race_err",  32'(rsp_err), 32'd0);
    chk("race_rdat", rsp_dat, 32'hCAFEF00D);
    step();
    chk("race_rv_drop", 32'(rsp_valid), 32'd0);
`else
    // No timeout logic: the master waits indefinitely
    issue(1'b0, 32'hBAD00000, 32'h0);
    low_cnt = 0;
    rv_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (!cyc) low_cnt++;
      if (rsp_valid) rv_cnt++;
    end
    chk("wait_cyc_low", 32'(low_cnt), 32'd0);
    chk("wait_rv",      32'(rv_cnt), 32'd0);
    chk("wait_ready",   32'(cmd_ready), 32'd0);
    ack = 1'b1; dat_i = 32'h0BADF00D;
    step();
    ack = 1'b0; dat_i = '0;
    chk("wait_rv_end",  32'(rsp_valid), 32'd1);
    chk("wait_err_end", 32'(rsp_err), 32'd0);
    chk("wait_rdat",    rsp_dat, 32'h0BADF00D);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
